// File: rtl/avg_n_controller.sv
`default_nettype none
// ============================================================================
// Module      : avg_n_controller
// Description : Control FSM for an N-point moving-average datapath. Each
//               accepted (edge-qualified) data-ready loads a sample into slot
//               T=N+1, shifts the window R1..RN, clears R0, sums the window
//               into R0 with per-add overflow checking, then divides by N
//               with a logical right shift.
//
//   Ports:
//     clk        in   system clock, rising edge
//     nReset     in   asynchronous active-low reset
//     dr         in   data ready level
//     V          in   datapath overflow for the current op
//     cnt_up     out  one-cycle pulse per accepted sample (STORE)
//     modwait    out  registered busy flag
//     op         out  ALU op (NOP/LOAD/COPY/ADD/SUB/SHR)
//     src1/src2  out  source register indices
//     dest       out  destination register index
//     err        out  high while in the error idle state
//     avg_valid  out  pulse: R0 holds an average over a full window
//
// Revision    : 1.0 - initial release
// ============================================================================
module avg_n_controller #(
    parameter int SAMPLES = 4,
    parameter int REG_W   = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             dr,
    input  logic             V,
    output logic             cnt_up,
    output logic             modwait,
    output logic [2:0]       op,
    output logic [REG_W-1:0] src1,
    output logic [REG_W-1:0] src2,
    output logic [REG_W-1:0] dest,
    output logic             err,
    output logic             avg_valid
);

    localparam int CNT_W = $clog2(SAMPLES + 1);

    localparam logic [CNT_W-1:0] C_N     = CNT_W'(SAMPLES);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [REG_W-1:0] C_T_REG = REG_W'(SAMPLES + 1);

    localparam logic [2:0] C_OP_NOP  = 3'b000;
    localparam logic [2:0] C_OP_LOAD = 3'b001;
    localparam logic [2:0] C_OP_COPY = 3'b010;
    localparam logic [2:0] C_OP_ADD  = 3'b011;
    localparam logic [2:0] C_OP_SUB  = 3'b100;
    localparam logic [2:0] C_OP_SHR  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STORE = 3'd1,
        S_SHIFT = 3'd2,
        S_ZERO  = 3'd3,
        S_ADD   = 3'd4,
        S_DIV   = 3'd5,
        S_EIDLE = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;        // SHIFT down-counter k / ADD up-counter i
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_fill;       // samples in the window, saturates at N
    logic             r_armed;      // dr has been seen low since last accept
    logic             w_accept;
    logic             w_busy_nxt;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_EIDLE: begin
                if (dr && r_armed) begin
                    w_state_nxt = S_STORE;
                    w_accept    = 1'b1;
                end
            end
            S_STORE: begin
                // dr dropping during STORE means the sample was lost
                if (dr) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = C_N;
                end else begin
                    w_state_nxt = S_EIDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt > C_ONE) begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end else begin
                    w_state_nxt = S_ZERO;
                    w_cnt_nxt   = '0;
                end
            end
            S_ZERO: begin
                w_state_nxt = S_ADD;
                w_cnt_nxt   = C_ONE;
            end
            S_ADD: begin
                if (V) begin
                    w_state_nxt = S_EIDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt < C_N) begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end else begin
                    w_state_nxt = S_DIV;
                    w_cnt_nxt   = '0;
                end
            end
            S_DIV: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == S_STORE) || (w_state_nxt == S_SHIFT) ||
                        (w_state_nxt == S_ZERO)  || (w_state_nxt == S_ADD)   ||
                        (w_state_nxt == S_DIV);

    // ------------------------------------------------------------------
    // State, counters and registered status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_armed   <= 1'b1;
            r_fill    <= '0;
            modwait   <= 1'b0;
            avg_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;

            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!dr) begin
                r_armed <= 1'b1;
            end

            // Any abort invalidates the window contents
            if (w_state_nxt == S_EIDLE) begin
                r_fill <= '0;
            end else if ((r_state == S_STORE) && dr && (r_fill != C_N)) begin
                r_fill <= r_fill + C_ONE;
            end

            // Busy is registered from the next state so it never glitches
            modwait   <= w_busy_nxt;
            avg_valid <= (r_state == S_DIV) && (r_fill == C_N);
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        op     = C_OP_NOP;
        src1   = '0;
        src2   = '0;
        dest   = '0;
        cnt_up = 1'b0;
        err    = 1'b0;
        case (r_state)
            S_STORE: begin
                op     = C_OP_LOAD;
                dest   = C_T_REG;
                cnt_up = 1'b1;
            end
            S_SHIFT: begin
                op   = C_OP_COPY;
                dest = REG_W'(r_cnt);
                // R1 takes the freshly loaded sample from slot T
                src1 = (r_cnt == C_ONE) ? C_T_REG : REG_W'(r_cnt - C_ONE);
            end
            S_ZERO: begin
                op = C_OP_SUB;
            end
            S_ADD: begin
                op   = C_OP_ADD;
                src2 = REG_W'(r_cnt);
            end
            S_DIV: begin
                op = C_OP_SHR;
            end
            S_EIDLE: begin
                err = 1'b1;
            end
            default: begin
                op = C_OP_NOP;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_avg_n_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_avg_n_controller
// Description : Directed self-checking bench for avg_n_controller, with an
//               N=4 instance and an N=8 instance sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avg_n_controller;

    logic       clk;
    logic       nReset;
    logic       dr4, v4, dr8, v8;
    logic       cu4, mw4, er4, av4, cu8, mw8, er8, av8;
    logic [2:0] op4, op8;
    logic [3:0] s14, s24, d4, s18, s28, d8;

    int errors = 0;
    int checks = 0;

    // Per-cycle record of the last run, index = cycle after dr asserted
    logic [2:0] rec_op [0:63];
    logic [3:0] rec_s1 [0:63];
    logic [3:0] rec_s2 [0:63];
    logic [3:0] rec_d  [0:63];
    logic       rec_cu [0:63];
    logic       rec_mw [0:63];
    logic       rec_er [0:63];
    logic       rec_av [0:63];

    avg_n_controller #(.SAMPLES(4), .REG_W(4)) dut4 (
        .clk(clk), .nReset(nReset), .dr(dr4), .V(v4),
        .cnt_up(cu4), .modwait(mw4), .op(op4), .src1(s14), .src2(s24),
        .dest(d4), .err(er4), .avg_valid(av4)
    );

    avg_n_controller #(.SAMPLES(8), .REG_W(4)) dut8 (
        .clk(clk), .nReset(nReset), .dr(dr8), .V(v8),
        .cnt_up(cu8), .modwait(mw8), .op(op8), .src1(s18), .src2(s28),
        .dest(d8), .err(er8), .avg_valid(av8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        nReset = 1'b0;
        dr4 = 1'b0; v4 = 1'b0; dr8 = 1'b0; v8 = 1'b0;
        repeat (2) @(negedge clk);
        nReset = 1'b1;
    endtask

    // Raise dr, record ncyc cycles; dr drops after cycle dr_hi is recorded,
    // V is high for the edge that ends recorded cycle v_cyc.
    task automatic run(input int which, input int ncyc, input int dr_hi, input int v_cyc);
        if (which == 8) dr8 = 1'b1; else dr4 = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (which == 8) begin
                rec_op[c] = op8; rec_s1[c] = s18; rec_s2[c] = s28; rec_d[c] = d8;
                rec_cu[c] = cu8; rec_mw[c] = mw8; rec_er[c] = er8; rec_av[c] = av8;
            end else begin
                rec_op[c] = op4; rec_s1[c] = s14; rec_s2[c] = s24; rec_d[c] = d4;
                rec_cu[c] = cu4; rec_mw[c] = mw4; rec_er[c] = er4; rec_av[c] = av4;
            end
            if (c == dr_hi) begin
                dr4 = 1'b0; dr8 = 1'b0;
            end
            v4 = (which == 4) && (c == v_cyc);
            v8 = (which == 8) && (c == v_cyc);
        end
        dr4 = 1'b0; dr8 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        if ({op4, s14, s24, d4, cu4, mw4, er4, av4} !== 20'd0) begin
            errors++;
            $display("FAIL reset_n4: got %h expected 0", {op4, s14, s24, d4, cu4, mw4, er4, av4});
        end
        checks++;
        if ({op8, s18, s28, d8, cu8, mw8, er8, av8} !== 20'd0) begin
            errors++;
            $display("FAIL reset_n8: got %h expected 0", {op8, s18, s28, d8, cu8, mw8, er8, av8});
        end
        checks++;
    endtask

    task automatic test_basic();
        logic [2:0]  eop [1:11] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5};
        logic [3:0]  ed  [1:11] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        logic [3:0]  es1 [1:11] = '{4'd0, 4'd3, 4'd2, 4'd1, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        logic [3:0]  es2 [1:11] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        int nmw = 0, ncu = 0, nav = 0;
        do_reset();
        run(4, 13, 2, 0);
        for (int c = 1; c <= 11; c++) begin
            if ({rec_op[c], rec_s1[c], rec_s2[c], rec_d[c]} !== {eop[c], es1[c], es2[c], ed[c]}) begin
                errors++;
                $display("FAIL basic_decode c=%0d: got op=%0d s1=%0d s2=%0d d=%0d expected op=%0d s1=%0d s2=%0d d=%0d",
                         c, rec_op[c], rec_s1[c], rec_s2[c], rec_d[c], eop[c], es1[c], es2[c], ed[c]);
            end
            checks++;
        end
        for (int c = 1; c <= 13; c++) begin
            nmw += int'(rec_mw[c]); ncu += int'(rec_cu[c]); nav += int'(rec_av[c]);
        end
        if (nmw !== 11) begin errors++; $display("FAIL basic_busy: got %0d expected 11", nmw); end
        checks++;
        if (ncu !== 1 || rec_cu[1] !== 1'b1) begin
            errors++; $display("FAIL basic_cnt_up: got %0d pulses expected 1 at STORE", ncu);
        end
        checks++;
        if (nav !== 0) begin errors++; $display("FAIL basic_avg_valid: got %0d expected 0", nav); end
        checks++;
        if ({rec_mw[11], rec_mw[12], rec_op[12]} !== {1'b1, 1'b0, 3'd0}) begin
            errors++; $display("FAIL basic_end: got mw11=%0d mw12=%0d op12=%0d expected 1 0 0",
                               rec_mw[11], rec_mw[12], rec_op[12]);
        end
        checks++;
    endtask

    // Conversions 2..4 also pulse V during SHIFT, ZERO and DIV, which must be ignored
    task automatic test_warmup();
        int vsel [1:5] = '{0, 3, 6, 11, 0};
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            int nav = 0, ner = 0, nmw = 0;
            run(4, 13, 2, vsel[k]);
            for (int c = 1; c <= 13; c++) begin
                nav += int'(rec_av[c]); ner += int'(rec_er[c]); nmw += int'(rec_mw[c]);
            end
            if (nav !== ((k >= 4) ? 1 : 0) || rec_av[12] !== (k >= 4)) begin
                errors++; $display("FAIL warmup_valid conv=%0d: got %0d (c12=%0d) expected %0d",
                                   k, nav, rec_av[12], (k >= 4) ? 1 : 0);
            end
            checks++;
            if (ner !== 0 || nmw !== 11) begin
                errors++; $display("FAIL warmup_v_ignored conv=%0d: got err=%0d busy=%0d expected 0 11", k, ner, nmw);
            end
            checks++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 4; k++) run(4, 13, 2, 0);
        run(4, 12, 2, 9);
        if ({rec_er[10], rec_mw[10], rec_op[10]} !== {1'b1, 1'b0, 3'd0}) begin
            errors++; $display("FAIL ovf_eidle: got err=%0d mw=%0d op=%0d expected 1 0 0",
                               rec_er[10], rec_mw[10], rec_op[10]);
        end
        checks++;
        if (rec_er[12] !== 1'b1) begin errors++; $display("FAIL ovf_err_hold: got %0d expected 1", rec_er[12]); end
        checks++;
        for (int k = 1; k <= 4; k++) begin
            int nav = 0;
            run(4, 13, 2, 0);
            for (int c = 1; c <= 13; c++) nav += int'(rec_av[c]);
            if (k == 1 && rec_er[1] !== 1'b0) begin
                errors++; $display("FAIL ovf_err_clear: got %0d expected 0", rec_er[1]);
            end
            if (k == 1) checks++;
            if (nav !== ((k == 4) ? 1 : 0)) begin
                errors++; $display("FAIL ovf_fill conv=%0d: got %0d expected %0d", k, nav, (k == 4) ? 1 : 0);
            end
            checks++;
        end
    endtask

    task automatic test_dr_drop();
        int ncu = 0, ncopy = 0;
        do_reset();
        run(4, 6, 1, 0);
        for (int c = 1; c <= 6; c++) begin
            ncu += int'(rec_cu[c]); ncopy += int'(rec_op[c] == 3'd2);
        end
        if ({rec_er[2], rec_mw[2], rec_er[6]} !== 3'b101) begin
            errors++; $display("FAIL drop_eidle: got err=%0d mw=%0d err6=%0d expected 1 0 1", rec_er[2], rec_mw[2], rec_er[6]);
        end
        checks++;
        if (ncu !== 1 || ncopy !== 0) begin
            errors++; $display("FAIL drop_ops: got cnt_up=%0d copies=%0d expected 1 0", ncu, ncopy);
        end
        checks++;
    endtask

    task automatic test_held();
        int ncu = 0, nmw = 0, nop = 0;
        do_reset();
        run(4, 45, 40, 0);
        for (int c = 1; c <= 45; c++) begin
            ncu += int'(rec_cu[c]); nmw += int'(rec_mw[c]); nop += int'(rec_op[c] != 3'd0);
        end
        if (ncu !== 1 || nmw !== 11 || nop !== 11) begin
            errors++; $display("FAIL held_no_retrigger: got cnt_up=%0d busy=%0d ops=%0d expected 1 11 11", ncu, nmw, nop);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int nmw = 0, nav = 0;
        do_reset();
        for (int k = 1; k <= 4; k++) run(4, 13, 2, 0);
        dr4 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) dr4 = 1'b0;
        end
        if ({op4, s24} !== {3'd3, 4'd2}) begin
            errors++; $display("FAIL rstmid_add2: got op=%0d src2=%0d expected 3 2", op4, s24);
        end
        checks++;
        #2 nReset = 1'b0;
        #1;
        if ({op4, s14, s24, d4, cu4, mw4, er4, av4} !== 20'd0) begin
            errors++; $display("FAIL rstmid_async: got %h expected 0", {op4, s14, s24, d4, cu4, mw4, er4, av4});
        end
        checks++;
        @(negedge clk);
        nReset = 1'b1;
        run(4, 13, 2, 0);
        for (int c = 1; c <= 13; c++) begin
            nmw += int'(rec_mw[c]); nav += int'(rec_av[c]);
        end
        if (nmw !== 11 || nav !== 0 || rec_op[11] !== 3'd5) begin
            errors++; $display("FAIL rstmid_after: got busy=%0d valid=%0d op11=%0d expected 11 0 5", nmw, nav, rec_op[11]);
        end
        checks++;
    endtask

    task automatic test_param8();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            int nmw = 0, nav = 0;
            run(8, 21, 2, 0);
            for (int c = 1; c <= 21; c++) begin
                nmw += int'(rec_mw[c]); nav += int'(rec_av[c]);
            end
            if (nmw !== 19 || rec_op[19] !== 3'd5 || rec_d[1] !== 4'd9) begin
                errors++; $display("FAIL n8_seq conv=%0d: got busy=%0d op19=%0d dest1=%0d expected 19 5 9",
                                   k, nmw, rec_op[19], rec_d[1]);
            end
            checks++;
            if (k == 1 && {rec_d[9], rec_s1[9], rec_d[2], rec_s1[2]} !== {4'd1, 4'd9, 4'd8, 4'd7}) begin
                errors++; $display("FAIL n8_shift: got d9=%0d s9=%0d d2=%0d s2=%0d expected 1 9 8 7",
                                   rec_d[9], rec_s1[9], rec_d[2], rec_s1[2]);
            end
            if (k == 1) checks++;
            if (nav !== ((k == 8) ? 1 : 0) || rec_av[20] !== (k == 8)) begin
                errors++; $display("FAIL n8_valid conv=%0d: got %0d expected %0d", k, nav, (k == 8) ? 1 : 0);
            end
            checks++;
        end
    endtask

    initial begin
        nReset = 1'b0;
        dr4 = 1'b0; v4 = 1'b0; dr8 = 1'b0; v8 = 1'b0;
        test_reset();
        test_basic();
        test_warmup();
        test_overflow();
        test_dr_drop();
        test_held();
        test_reset_mid();
        test_param8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avg_n_controller.md
# avg_n_controller

Parametrised control FSM for the N-point moving-average datapath. Each accepted data-ready event loads a new sample, shifts the sample window, clears the accumulator, sums the window with per-add overflow checking, and divides by N with a shift. It drives the register-file/ALU datapath through op/src1/src2/dest, and reports busy, sample-count, completion and error to the surrounding top level. Compared with the fixed 4-sample controller, it adds:
- sample-count generalisation,
- warm-up tracking,
- a glitch-free registered busy flag,
- edge-qualified data-ready.

## Interface
- SAMPLES, 4: window length N; power of two, 2..16.
- REG_W, 4: register index width; must satisfy 2^REG_W >= SAMPLES+2.
- clk  in  1  system clock, all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- dr  in  1  data ready (level from input sync).
- V  in  1  datapath overflow, combinational result of the current op.
- cnt_up  out  1  one-cycle pulse per accepted sample.
- modwait  out  1  busy flag, registered.
- op  out  3  ALU op: 000 NOP, 001 LOAD (dest<=ext), 010 COPY (dest<=src1), 011 ADD (dest<=src1+src2), 100 SUB (dest<=src1-src2), 101 SHR (dest<=src1>>log2(SAMPLES), logical).
- src1, src2, dest  out  REG_W each  register indices.
- err  out  1  error indication.
- avg_valid  out  1  one-cycle pulse: R0 holds a valid average over a full window.

## Operation
- **Register map**
  - R0 is the accumulator/result.
  - R1..RN is the window; R1 is newest.
  - T = N+1 is the incoming-sample slot.
- **States:** IDLE, STORE, SHIFT (down-counter k), ZERO, ADD (up-counter i), DIV, EIDLE.
- **Outputs per state** (op/src1/src2/dest are Moore decode of state; unlisted indices are 0):
  - IDLE: NOP.
  - STORE: LOAD, dest=T; cnt_up=1.
  - SHIFT k, for k=N down to 1: COPY, dest=k, src1=k-1. When k=1, src1=T instead.
  - ZERO: SUB, src1=0, src2=0, dest=0.
  - ADD i, for i=1..N: ADD, src1=0, src2=i, dest=0.
  - DIV: SHR, src1=0, dest=0.
  - EIDLE: NOP; err=1.
- **Data-ready arming:** the internal flag `armed` sets when dr is sampled low.
- **Transitions**
  - IDLE/EIDLE, dr=1 and armed → STORE; this clears armed.
  - STORE, dr=1 → SHIFT k=N.
  - STORE, dr=0 → EIDLE (sample lost).
  - SHIFT k>1 → SHIFT k-1.
  - SHIFT k=1 → ZERO.
  - ZERO → ADD i=1.
  - ADD, V=1 → EIDLE.
  - ADD, V=0 with i<N → ADD i+1.
  - ADD, V=0 with i=N → DIV.
  - DIV → IDLE.
  - In IDLE/EIDLE with dr=1 but not armed: stay.
- **Fill counter**
  - Width clog2(N+1), saturating at N.
  - Increments on each STORE→SHIFT transition.
  - Clears on reset and on any entry to EIDLE.
- **avg_valid:** registered; high for the single cycle after DIV, only if fill==N at DIV.
- **modwait:** flop whose D = (next state ∈ {STORE, SHIFT, ZERO, ADD, DIV}).
- **err:** Moore, high exactly while in EIDLE. It stays high until a new armed dr is accepted.
- **Reset values:**
  - state=IDLE, armed=1, fill=0, counters=0.
  - modwait=0, cnt_up=0, err=0, avg_valid=0, op=000, src1/src2/dest=0.

## Timing
- Reset mid-operation aborts immediately: outputs take reset values asynchronously, and no datapath op is issued after nReset falls.
- dr sampled at edge E (IDLE, armed): STORE occupies E+1..E+2.
- Busy length is 2N+3 cycles: STORE, N SHIFT, ZERO, N ADD, DIV. For N=4 this is 11 cycles.
- modwait rises at the edge entering STORE and falls at the edge leaving DIV or entering EIDLE. It has no combinational glitches.
- V is sampled at the end of each ADD cycle only. V during SHIFT/ZERO/DIV is ignored.
- cnt_up is coincident with STORE, exactly one cycle per accepted sample, including samples later aborted to EIDLE.
- Back-to-back samples: dr must return low at least one cycle before the next acceptance. A dr held high through DIV does not retrigger.

## Test plan
- **Basic conversion:** N=4, reset, then dr pulse high for 2 cycles.
  - modwait high for exactly 11 cycles; cnt_up pulses once.
  - op sequence: 001, 010×4, 100, 011×4, 101.
  - dest sequence: 5, 4, 3, 2, 1, 0 ×6.
  - SHIFT src1 sequence: 3, 2, 1, 5.
- **Warm-up:** 4 consecutive conversions.
  - avg_valid stays 0 after conversions 1–3.
  - avg_valid pulses one cycle after DIV of conversion 4, and after every later conversion.
- **Overflow:** force V=1 during ADD i=3.
  - Next cycle in EIDLE: err=1, modwait=0, op=000.
  - fill cleared: the next 3 conversions give no avg_valid.
  - A new dr pulse clears err one cycle after acceptance.
- **dr drop:** dr high 1 cycle only (low during STORE).
  - EIDLE, err=1, cnt_up pulsed once, no COPY issued.
- **dr held high 40 cycles:** exactly one conversion runs; no retrigger after DIV.
- **Reset mid-ADD:** assert nReset low during ADD i=2.
  - All outputs zero immediately.
  - After release, a dr pulse yields a full 11-cycle sequence with avg_valid=0.
- **Parametrisation:** SAMPLES=8, REG_W=4.
  - Busy 19 cycles, T=9, DIV uses op 101.
  - avg_valid only after the 8th sample.
